// File: rtl/uart_avmm_host_pkg.sv
// Shared definitions for the UART Avalon-MM host: FSM states and uart_core register map.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_avmm_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ST_RD,
    ST_WAIT,
    GAP,
    TX_WR,
    RX_RD,
    RX_WAIT,
    HOLD
  } state_t;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_RXDATA = 4'h2;

  localparam int STATUS_TXRDY_BIT = 0;

endpackage

// File: rtl/uart_host_fifo.sv
// First-word-fall-through synchronous FIFO for received bytes.
// Latency: a pushed byte appears on rdata the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; full/empty/count exported.
// Ports: clk_i/srst_i clock and sync reset; push/wdata write side; pop/rdata read side;
//        full, empty, count status.
module uart_host_fifo #(
  parameter int RX_DEPTH = 8,
  parameter int WIDTH    = 8
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(RX_DEPTH):0]   count
);

  localparam int AW = $clog2(RX_DEPTH);

  logic [WIDTH-1:0] mem [RX_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (AW+1)'(RX_DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because RX_DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_avmm_host.sv
// Avalon-MM initiator driving uart_core: polls STATUS and writes TX bytes, drains RXDATA on IRQ.
// Latency: tx byte sampled at N -> STATUS read at N+1 -> TXDATA write at N+3 when TX ready.
// Backpressure: tx_ready_o pulses only on the TXDATA write; RX reads stall while the FIFO is full.
// Ports: clk_i/srst_i clock and sync reset; tx_* outgoing byte stream; rx_* received byte stream;
//        avm_* Avalon-MM initiator (read latency 1, no waitrequest); irq_i uart_core IRQ level.
module uart_avmm_host
  import uart_avmm_host_pkg::*;
#(
  parameter int RX_DEPTH    = 8,
  parameter int POLL_GAP    = 4,
  parameter int IRQ_HOLDOFF = 2
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic [3:0] avm_address_o,
  output logic       avm_read_o,
  output logic       avm_write_o,
  output logic [7:0] avm_writedata_o,
  input  logic [7:0] avm_readdata_i,
  input  logic       irq_i
);

  localparam int CW   = 8;
  localparam int CNTW = $clog2(RX_DEPTH) + 1;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] rx_count_unused;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        // IRQ wins over TX; a full FIFO leaves the IRQ pending so TX can still run.
        if (irq_i && !fifo_full) begin
          state_nxt = RX_RD;
        end else if (tx_valid_i) begin
          state_nxt = ST_RD;
        end
      end
      ST_RD: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (avm_readdata_i[STATUS_TXRDY_BIT]) begin
          // A byte withdrawn during polling is never written.
          state_nxt = tx_valid_i ? TX_WR : IDLE;
        end else if (POLL_GAP == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = GAP;
          cnt_nxt   = CW'(POLL_GAP - 1);
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      TX_WR: state_nxt = IDLE;
      RX_RD: state_nxt = RX_WAIT;
      RX_WAIT: begin
        if (IRQ_HOLDOFF == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
          cnt_nxt   = CW'(IRQ_HOLDOFF - 1);
        end
      end
      HOLD: begin
        // irq_i is ignored here while uart_core clears it after the RXDATA read.
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      avm_read_o      <= 1'b0;
      avm_write_o     <= 1'b0;
      avm_address_o   <= '0;
      avm_writedata_o <= '0;
      tx_ready_o      <= 1'b0;
    end else begin
      avm_read_o      <= (state_nxt == ST_RD) || (state_nxt == RX_RD);
      avm_write_o     <= (state_nxt == TX_WR);
      tx_ready_o      <= (state_nxt == TX_WR);
      avm_writedata_o <= (state_nxt == TX_WR) ? tx_data_i : 8'h00;
      if (state_nxt == ST_RD)      avm_address_o <= ADDR_STATUS;
      else if (state_nxt == RX_RD) avm_address_o <= ADDR_RXDATA;
      else                         avm_address_o <= ADDR_TXDATA;
    end
  end

  assign fifo_push  = (state == RX_WAIT);
  assign fifo_pop   = rx_valid_o && rx_ready_i;
  assign rx_valid_o = !fifo_empty;

  uart_host_fifo #(
    .RX_DEPTH (RX_DEPTH),
    .WIDTH    (8)
  ) u_rx_fifo (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .push   (fifo_push),
    .wdata  (avm_readdata_i),
    .pop    (fifo_pop),
    .rdata  (rx_data_o),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (rx_count_unused)
  );

endmodule

// File: tb/tb_uart_avmm_host.sv
// Directed bench for uart_avmm_host with a small uart_core responder and bus monitor.
// Latency: n/a.
// Backpressure: rx_ready_i held low to fill the FIFO, then pulsed to drain it.
module tb_uart_avmm_host;

  logic       clk_i = 1'b0;
  logic       srst_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [3:0] avm_address_o;
  logic       avm_read_o;
  logic       avm_write_o;
  logic [7:0] avm_writedata_o;
  logic [7:0] avm_readdata_i;
  logic       irq_i;

  int checks = 0;
  int errors = 0;

  uart_avmm_host #(.RX_DEPTH(8), .POLL_GAP(4), .IRQ_HOLDOFF(2)) dut (
    .clk_i           (clk_i),
    .srst_i          (srst_i),
    .tx_data_i       (tx_data_i),
    .tx_valid_i      (tx_valid_i),
    .tx_ready_o      (tx_ready_o),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .avm_address_o   (avm_address_o),
    .avm_read_o      (avm_read_o),
    .avm_write_o     (avm_write_o),
    .avm_writedata_o (avm_writedata_o),
    .avm_readdata_i  (avm_readdata_i),
    .irq_i           (irq_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // uart_core responder: read data one cycle after the strobe, IRQ clears one cycle after RXDATA read.
  logic [7:0] status_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rd_next = 8'h00;
  logic       irq_lvl = 1'b0;
  always @(posedge clk_i) begin
    #1;
    avm_readdata_i = rd_next;
    rd_next = 8'h00;
    irq_i = irq_lvl;
    if (avm_read_o && avm_address_o == 4'h1) begin
      if (status_q.size() != 0) rd_next = status_q.pop_front();
      else                      rd_next = 8'h01;
    end
    if (avm_read_o && avm_address_o == 4'h2) begin
      if (rx_q.size() != 0) rd_next = rx_q.pop_front();
      else                  rd_next = 8'hEE;
    end
    irq_lvl = (rx_q.size() != 0);
  end

  // Bus monitor: event log plus protocol violation counter.
  bit         ev_wr[$];
  logic [3:0] ev_addr[$];
  logic [7:0] ev_data[$];
  int         ev_cyc[$];
  int         viol = 0;
  int         rdy_cnt = 0;
  int         rdy_cyc = 0;
  logic       prev_rd = 1'b0;
  logic       prev_wr = 1'b0;
  always @(negedge clk_i) begin
    if (avm_read_o || avm_write_o) begin
      ev_wr.push_back(avm_write_o);
      ev_addr.push_back(avm_address_o);
      ev_data.push_back(avm_writedata_o);
      ev_cyc.push_back(cyc);
    end
    if (tx_ready_o) begin
      rdy_cnt++;
      rdy_cyc = cyc;
    end
    if (avm_read_o && avm_write_o) viol++;
    if (!avm_read_o && !avm_write_o && (avm_address_o != 4'h0 || avm_writedata_o != 8'h00)) viol++;
    if (tx_ready_o !== avm_write_o) viol++;
    if ((avm_read_o && prev_rd) || (avm_write_o && prev_wr)) viol++;
    prev_rd = avm_read_o;
    prev_wr = avm_write_o;
  end

  task automatic clear_log();
    ev_wr.delete();
    ev_addr.delete();
    ev_data.delete();
    ev_cyc.delete();
    rdy_cnt = 0;
  endtask

  function automatic int count_ev(input bit wr, input logic [3:0] addr);
    int n = 0;
    for (int i = 0; i < ev_wr.size(); i++)
      if (ev_wr[i] == wr && ev_addr[i] == addr) n++;
    return n;
  endfunction

  task automatic wait_tx_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (tx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    tx_valid_i = 1'b0;
  endtask

  task automatic pop_byte(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    for (int i = 0; i < 60; i++) begin
      if (rx_valid_o) begin
        d = rx_data_o;
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    bit found;
    srst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (avm_read_o !== 1'b0)    begin errors++; $display("FAIL reset_read got %0b want 0", avm_read_o); end
    checks++; if (avm_write_o !== 1'b0)   begin errors++; $display("FAIL reset_write got %0b want 0", avm_write_o); end
    checks++; if (avm_address_o !== 4'h0) begin errors++; $display("FAIL reset_addr got %0h want 0", avm_address_o); end
    checks++; if (tx_ready_o !== 1'b0)    begin errors++; $display("FAIL reset_txrdy got %0b want 0", tx_ready_o); end
    checks++; if (rx_valid_o !== 1'b0)    begin errors++; $display("FAIL reset_rxvld got %0b want 0", rx_valid_o); end
    srst_i = 1'b0;

    // Park a byte in the FIFO so the mid-operation reset has something to discard.
    rx_q.push_back(8'hA5);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (rx_valid_o) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL reset_preload got rx_valid=0 want 1"); end
    repeat (6) @(negedge clk_i);

    clear_log();
    tx_data_i = 8'h55;
    tx_valid_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (avm_read_o) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL reset_poll_start got no STATUS read want one"); end
    srst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (avm_read_o !== 1'b0)    begin errors++; $display("FAIL abort_read got %0b want 0", avm_read_o); end
    checks++; if (avm_write_o !== 1'b0)   begin errors++; $display("FAIL abort_write got %0b want 0", avm_write_o); end
    checks++; if (avm_address_o !== 4'h0) begin errors++; $display("FAIL abort_addr got %0h want 0", avm_address_o); end
    checks++; if (tx_ready_o !== 1'b0)    begin errors++; $display("FAIL abort_txrdy got %0b want 0", tx_ready_o); end
    checks++; if (rx_valid_o !== 1'b0)    begin errors++; $display("FAIL abort_fifo_flush got %0b want 0", rx_valid_o); end
    repeat (2) @(negedge clk_i);
    srst_i = 1'b0;
    tx_valid_i = 1'b0;
    repeat (20) @(negedge clk_i);
    checks++; if (count_ev(1'b1, 4'h0) != 0) begin errors++; $display("FAIL abort_no_write got %0d writes want 0", count_ev(1'b1, 4'h0)); end
  endtask

  task automatic test_single_tx();
    int c0;
    bit ok;
    clear_log();
    c0 = cyc;
    tx_data_i = 8'h48;
    tx_valid_i = 1'b1;
    wait_tx_done(ok);
    repeat (5) @(negedge clk_i);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got no tx_ready want pulse"); end
    checks++;
    if (ev_wr.size() != 2) begin
      errors++; $display("FAIL single_events got %0d want 2", ev_wr.size());
    end else begin
      checks++; if (ev_wr[0] || ev_addr[0] != 4'h1 || ev_cyc[0] != c0 + 1)
        begin errors++; $display("FAIL single_read got wr=%0b addr=%0h cyc=%0d want rd addr=1 cyc=%0d", ev_wr[0], ev_addr[0], ev_cyc[0], c0 + 1); end
      checks++; if (!ev_wr[1] || ev_addr[1] != 4'h0 || ev_data[1] != 8'h48 || ev_cyc[1] != c0 + 3)
        begin errors++; $display("FAIL single_write got addr=%0h data=%0h cyc=%0d want addr=0 data=48 cyc=%0d", ev_addr[1], ev_data[1], ev_cyc[1], c0 + 3); end
    end
    checks++; if (rdy_cnt != 1 || rdy_cyc != c0 + 3)
      begin errors++; $display("FAIL single_txrdy got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", rdy_cnt, rdy_cyc, c0 + 3); end
  endtask

  task automatic test_busy_poll();
    int c0;
    bit ok;
    int exp_cyc[5];
    clear_log();
    status_q.push_back(8'h00);
    status_q.push_back(8'h00);
    status_q.push_back(8'h00);
    status_q.push_back(8'h01);
    // Reads every POLL_GAP+3 = 7 cycles, write two cycles after the last read.
    exp_cyc = '{1, 8, 15, 22, 24};
    c0 = cyc;
    tx_data_i = 8'h4F;
    tx_valid_i = 1'b1;
    wait_tx_done(ok);
    repeat (5) @(negedge clk_i);
    checks++; if (!ok) begin errors++; $display("FAIL busy_timeout got no tx_ready want pulse"); end
    checks++;
    if (ev_wr.size() != 5) begin
      errors++; $display("FAIL busy_events got %0d want 5", ev_wr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (ev_wr[i] || ev_addr[i] != 4'h1 || ev_cyc[i] != c0 + exp_cyc[i])
          begin errors++; $display("FAIL busy_read%0d got wr=%0b addr=%0h cyc=%0d want rd addr=1 cyc=%0d", i, ev_wr[i], ev_addr[i], ev_cyc[i], c0 + exp_cyc[i]); end
      end
      checks++; if (!ev_wr[4] || ev_data[4] != 8'h4F || ev_cyc[4] != c0 + exp_cyc[4])
        begin errors++; $display("FAIL busy_write got data=%0h cyc=%0d want data=4f cyc=%0d", ev_data[4], ev_cyc[4], c0 + exp_cyc[4]); end
    end
  endtask

  task automatic test_rx();
    bit found;
    bit ok;
    logic [7:0] d;
    clear_log();
    rx_q.push_back(8'h6E);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (rx_valid_o) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rx_valid got 0 want 1"); end
    checks++; if (rx_data_o !== 8'h6E) begin errors++; $display("FAIL rx_data got %0h want 6e", rx_data_o); end
    repeat (10) @(negedge clk_i);
    checks++; if (count_ev(1'b0, 4'h2) != 1 || ev_wr.size() != 1)
      begin errors++; $display("FAIL rx_single_read got %0d rxdata reads of %0d events want 1 of 1", count_ev(1'b0, 4'h2), ev_wr.size()); end
    pop_byte(d, ok);
    @(negedge clk_i);
    checks++; if (!ok || d !== 8'h6E) begin errors++; $display("FAIL rx_pop got ok=%0b data=%0h want 6e", ok, d); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rx_empty got %0b want 0", rx_valid_o); end
  endtask

  task automatic test_priority();
    bit found;
    bit ok;
    logic [7:0] d;
    clear_log();
    rx_q.push_back(8'h21);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (irq_i) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL prio_irq got irq=0 want 1"); end
    tx_data_i = 8'h33;
    tx_valid_i = 1'b1;
    wait_tx_done(ok);
    repeat (5) @(negedge clk_i);
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout got no tx_ready want pulse"); end
    checks++;
    if (ev_wr.size() != 3) begin
      errors++; $display("FAIL prio_events got %0d want 3", ev_wr.size());
    end else begin
      checks++; if (ev_wr[0] || ev_addr[0] != 4'h2) begin errors++; $display("FAIL prio_first got wr=%0b addr=%0h want rd addr=2", ev_wr[0], ev_addr[0]); end
      checks++; if (ev_wr[1] || ev_addr[1] != 4'h1) begin errors++; $display("FAIL prio_second got wr=%0b addr=%0h want rd addr=1", ev_wr[1], ev_addr[1]); end
      checks++; if (!ev_wr[2] || ev_data[2] != 8'h33) begin errors++; $display("FAIL prio_third got wr=%0b data=%0h want wr data=33", ev_wr[2], ev_data[2]); end
    end
    pop_byte(d, ok);
    checks++; if (!ok || d !== 8'h21) begin errors++; $display("FAIL prio_rx got ok=%0b data=%0h want 21", ok, d); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    logic [7:0] d;
    clear_log();
    rx_ready_i = 1'b0;
    for (int i = 1; i <= 9; i++) rx_q.push_back(8'(i));
    repeat (80) @(negedge clk_i);
    checks++; if (count_ev(1'b0, 4'h2) != 8) begin errors++; $display("FAIL full_reads got %0d want 8", count_ev(1'b0, 4'h2)); end
    checks++; if (irq_i !== 1'b1) begin errors++; $display("FAIL full_irq_pending got %0b want 1", irq_i); end
    pop_byte(d, ok);
    checks++; if (!ok || d !== 8'h01) begin errors++; $display("FAIL full_pop0 got ok=%0b data=%0h want 01", ok, d); end
    repeat (20) @(negedge clk_i);
    checks++; if (count_ev(1'b0, 4'h2) != 9) begin errors++; $display("FAIL full_ninth_read got %0d want 9", count_ev(1'b0, 4'h2)); end
    for (int i = 2; i <= 9; i++) begin
      pop_byte(d, ok);
      checks++; if (!ok || d !== 8'(i)) begin errors++; $display("FAIL full_pop%0d got ok=%0b data=%0h want %0h", i - 1, ok, d, i); end
    end
    @(negedge clk_i);
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL full_drained got %0b want 0", rx_valid_o); end
  endtask

  task automatic test_protocol();
    checks++; if (viol != 0) begin errors++; $display("FAIL protocol got %0d violations want 0", viol); end
  endtask

  initial begin
    srst_i = 1'b1;
    tx_data_i = 8'h00;
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    avm_readdata_i = 8'h00;
    irq_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_single_tx();
    test_busy_poll();
    test_rx();
    test_priority();
    test_fifo_full();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
